// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a contiguous block of RAM words out as valid/ready.
// The RAM read latency is absorbed by a small FIFO. Reads are issued only
// while a FIFO slot is free for them (occupancy + inflight < fifo_depth), so
// consumer back-pressure never drops data.
module ram_stream_reader #(
   parameter int address_width = 10,
   parameter int data_width    = 8,
   parameter int fifo_depth    = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [address_width-1:0] base_addr,
   input  logic [address_width:0]   length,
   output logic                     busy,
   output logic                     done,
   output logic                     ram_enable,
   output logic [address_width-1:0] ram_address,
   input  logic [data_width-1:0]    ram_q,
   output logic                     out_valid,
   output logic [data_width-1:0]    out_data,
   input  logic                     out_ready
);

   localparam int ptr_w = $clog2(fifo_depth);
   localparam int cnt_w = ptr_w + 1;

   localparam logic [ptr_w-1:0]         ptr_one_c  = ptr_w'(1);
   localparam logic [cnt_w-1:0]         cnt_zero_c = cnt_w'(0);
   localparam logic [cnt_w-1:0]         cnt_one_c  = cnt_w'(1);
   localparam logic [cnt_w-1:0]         depth_c    = cnt_w'(fifo_depth);
   localparam logic [address_width-1:0] addr_one_c = address_width'(1);
   localparam logic [address_width:0]   rem_zero_c = (address_width + 1)'(0);
   localparam logic [address_width:0]   rem_one_c  = (address_width + 1)'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                   state_r, state_s;
   logic                     done_r, done_s;
   logic [address_width-1:0] addr_r;
   logic [address_width:0]   remaining_r;
   logic                     inflight_r;
   logic [data_width-1:0]    fifo_mem_r [fifo_depth];
   logic [ptr_w-1:0]         wr_ptr_r, rd_ptr_r;
   logic [cnt_w-1:0]         occ_r;
   logic [cnt_w-1:0]         credit_use_s;
   logic                     issue_s, pop_s, push_s, accept_s;

   // Issue/accept decisions and next-state logic for the IDLE/FETCH/DRAIN sequencer.
   always_comb begin
      state_s      = state_r;
      done_s       = 1'b0;
      credit_use_s = occ_r + cnt_w'(inflight_r);
      issue_s      = (state_r == FETCH) && (remaining_r != rem_zero_c) && (credit_use_s < depth_c);
      pop_s        = (occ_r != cnt_zero_c) && out_ready;
      push_s       = inflight_r;
      accept_s     = (state_r == IDLE) && start && (length != rem_zero_c);
      case (state_r)
         IDLE: begin
            if (start) begin
               if (length != rem_zero_c) begin
                  state_s = FETCH;
               end else begin
                  // Zero-length request completes immediately without touching the RAM.
                  done_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            if (remaining_r == rem_zero_c) begin
               state_s = DRAIN;
            end else begin
               state_s = FETCH;
            end
         end
         DRAIN: begin
            // Leave on the edge that pops the last word, so done follows it directly.
            if (!inflight_r && (((occ_r == cnt_one_c) && pop_s) || (occ_r == cnt_zero_c))) begin
               state_s = IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Sequencer state and the registered completion pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         done_r  <= done_s;
      end
   end

   // Address counter, words-left counter and the one-deep read-latency tracker.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_r      <= {address_width{1'b0}};
         remaining_r <= rem_zero_c;
         inflight_r  <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (accept_s) begin
            addr_r      <= base_addr;
            remaining_r <= length;
         end else if (issue_s) begin
            addr_r      <= addr_r + addr_one_c;
            remaining_r <= remaining_r - rem_one_c;
         end
      end
   end

   // Output FIFO: capture RAM data one cycle after each read, pop on handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < fifo_depth; i++) begin
            fifo_mem_r[i] <= {data_width{1'b0}};
         end
         wr_ptr_r <= {ptr_w{1'b0}};
         rd_ptr_r <= {ptr_w{1'b0}};
         occ_r    <= cnt_zero_c;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= ram_q;
            wr_ptr_r             <= wr_ptr_r + ptr_one_c;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ptr_one_c;
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + cnt_one_c;
            2'b01:   occ_r <= occ_r - cnt_one_c;
            default: occ_r <= occ_r;
         endcase
      end
   end

   assign busy        = (state_r != IDLE);
   assign done        = done_r;
   assign ram_enable  = issue_s;
   assign ram_address = addr_r;
   assign out_valid   = (occ_r != cnt_zero_c);
   assign out_data    = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: directed table, hand-written
// corner sequences and randomized transfers against a queue-based model.
module tb_ram_stream_reader;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int FD = 4;
   localparam int MEM_WORDS = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done, ram_enable, out_valid;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_q = '0;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;

   logic [DW-1:0] mem [MEM_WORDS];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   len;
      int            mode;        // 0 always ready, 1 stalled then ready, 2 random ready
      int            stall;       // cycles of out_ready low (mode 1)
      int            exp_done;    // expected done cycle after start edge, 0 = unchecked
      int            exp_stall_rd;// expected reads while stalled, -1 = unchecked
      bit            poke;        // extra start pulse while busy
   } vec_t;

   vec_t vecs [6];

   ram_stream_reader #(.address_width(AW), .data_width(DW), .fifo_depth(FD)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .ram_enable (ram_enable),
      .ram_address(ram_address),
      .ram_q      (ram_q),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready)
   );

   always #5 clock = ~clock;

   // RAM model with one-cycle registered read.
   always @(posedge clock) begin
      if (ram_enable) ram_q <= mem[ram_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Runs one transfer; must be called at a negedge. Returns at the negedge of the done cycle.
   task automatic run_transfer(input string tag, input logic [AW-1:0] b, input logic [AW:0] n,
                               input int mode, input int stall, input int exp_done,
                               input int exp_stall_rd, input bit poke);
      logic [DW-1:0] exp_q [$];
      int issued = 0, xfer = 0, done_cyc = -1, first_valid = -1, stall_rd = 0;
      int addr_bad = 0, data_bad = 0, max_out = 0, budget;
      logic busy1 = 1'b0;
      bit rdy;
      for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[(int'(b) + i) % MEM_WORDS]);
      budget    = 4 * int'(n) + 60;
      start     = 1'b1;
      base_addr = b;
      length    = n;
      out_ready = (mode == 0);
      for (int k = 1; k <= budget; k++) begin
         @(negedge clock);
         if (k == 1) busy1 = busy;
         if (poke && k == 2) begin
            start     = 1'b1;
            base_addr = ~b;
            length    = 11'd3;
         end else begin
            start = 1'b0;
         end
         if (ram_enable === 1'b1) begin
            if (ram_address !== (b + AW'(issued))) addr_bad++;
            issued++;
            if (k <= stall) stall_rd++;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (k > stall);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         if (out_valid === 1'b1 && rdy) begin
            if (first_valid < 0) first_valid = k;
            if (exp_q.size() == 0) data_bad++;
            else if (out_data !== exp_q.pop_front()) data_bad++;
            xfer++;
         end
         if (issued - xfer > max_out) max_out = issued - xfer;
         if (done === 1'b1) begin
            done_cyc = k;
            check({tag, "_busy_at_done"}, busy, 0);
            break;
         end
      end
      check({tag, "_done_seen"}, (done_cyc >= 0), 1);
      if (exp_done > 0) check({tag, "_done_cycle"}, done_cyc, exp_done);
      check({tag, "_reads"}, issued, int'(n));
      check({tag, "_words"}, xfer, int'(n));
      check({tag, "_addr_errs"}, addr_bad, 0);
      check({tag, "_data_errs"}, data_bad, 0);
      check({tag, "_credit_ok"}, (max_out <= FD), 1);
      check({tag, "_busy_c1"}, busy1, (n != 0));
      if (mode == 0 && n != 0) check({tag, "_first_valid"}, first_valid, 3);
      if (exp_stall_rd >= 0) check({tag, "_stall_reads"}, stall_rd, exp_stall_rd);
   endtask

   // One cycle after completion: no second done, nothing running.
   task automatic idle_check(input string tag);
      @(negedge clock);
      start = 1'b0;
      check({tag, "_idle_done"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_ren"}, ram_enable, 0);
      check({tag, "_idle_valid"}, out_valid, 0);
   endtask

   initial begin
      vecs[0] = '{10'h010, 11'd8,  0, 0,  11, -1, 1'b0};
      vecs[1] = '{10'h3FE, 11'd4,  0, 0,  7,  -1, 1'b0};
      vecs[2] = '{10'h000, 11'd16, 1, 10, 27,  4, 1'b0};
      vecs[3] = '{10'h155, 11'd0,  0, 0,  1,  -1, 1'b0};
      vecs[4] = '{10'h100, 11'd1,  0, 0,  4,  -1, 1'b0};
      vecs[5] = '{10'h020, 11'd6,  0, 0,  9,  -1, 1'b1};

      for (int i = 0; i < MEM_WORDS; i++) mem[i] = DW'(i);

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ren", ram_enable, 0);
      check("rst_raddr", ram_address, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      reset = 1'b0;
      @(negedge clock);

      // Directed table.
      for (int v = 0; v < 6; v++) begin
         run_transfer($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].mode,
                      vecs[v].stall, vecs[v].exp_done, vecs[v].exp_stall_rd, vecs[v].poke);
         idle_check($sformatf("vec%0d", v));
      end

      // Back-to-back: second start issued in the done cycle of the first.
      run_transfer("b2b_a", 10'h040, 11'd2, 0, 0, 5, -1, 1'b0);
      run_transfer("b2b_b", 10'h080, 11'd3, 0, 0, 6, -1, 1'b0);
      idle_check("b2b");

      // Reset in the middle of a stalled fetch, then a fresh transfer.
      start     = 1'b1;
      base_addr = 10'h200;
      length    = 11'd16;
      out_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      check("pre_rst_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ren", ram_enable, 0);
      check("mid_rst_raddr", ram_address, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_transfer("post_rst", 10'h050, 11'd5, 0, 0, 8, -1, 1'b0);
      idle_check("post_rst");

      // Randomized contents and back-pressure, including the full RAM.
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = DW'($urandom);
      run_transfer("full", 10'h000, 11'd1024, 2, 0, 0, -1, 1'b0);
      idle_check("full");
      for (int r = 0; r < 8; r++) begin
         run_transfer($sformatf("rnd%0d", r), AW'($urandom), 11'($urandom_range(1, 80)),
                      2, 0, 0, -1, 1'b0);
         idle_check($sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Reads a contiguous block of bytes from the read port of a dual-port RAM and presents them as a valid/ready stream. The block sits between a video-RAM `dpram` port (1-cycle registered read latency, `enable`/`address`/`q`) and a consumer such as the video line shifter. It drives RAM addresses and absorbs the read latency in a small credit-controlled FIFO, so consumer back-pressure never drops data.

## Interface
Parameters:
- `address_width`, 10, width of the RAM address; addresses wrap modulo 2^address_width
- `data_width`, 8, width of the RAM data and the stream data
- `fifo_depth`, 4, output FIFO entries; power of two, ≥2

Ports:
- `clock`  in  1  sole clock; all logic is rising-edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  request pulse; sampled only in IDLE
- `base_addr`  in  address_width  first address to read; latched on an accepted `start`
- `length`  in  address_width+1  number of words to read (0 … 2^address_width); latched on an accepted `start`
- `busy`  out  1  high from the cycle after an accepted `start` until transfer completion
- `done`  out  1  one-cycle completion pulse
- `ram_enable`  out  1  RAM read strobe
- `ram_address`  out  address_width  RAM read address
- `ram_q`  in  data_width  RAM read data; valid in the cycle after `ram_enable`
- `out_valid`  out  1  the FIFO head is valid
- `out_data`  out  data_width  the FIFO head word
- `out_ready`  in  1  consumer accepts; a transfer occurs when `out_valid` and `out_ready` are both high

## Operation
States: IDLE, FETCH, DRAIN.
- **IDLE:**
  - `start`=1 with `length`≠0 → FETCH. Latches `base_addr` into the address counter and `length` into `remaining`.
  - `start`=1 with `length`=0 → pulse `done` next cycle, stay IDLE; `busy` stays 0 and no RAM access occurs.
- **FETCH:**
  - Issue condition: `remaining`>0 and (occupancy + inflight) < `fifo_depth`.
  - When it holds, `ram_enable`=1 and `ram_address`=counter. On that edge the counter increments (wrapping 2^address_width−1 → 0), `remaining` decrements and inflight is set.
  - When inflight is set, `ram_q` is pushed into the FIFO on the next edge.
  - When `remaining`=0 → DRAIN.
- **DRAIN:** once inflight=0, occupancy=0 and the last word has transferred → IDLE with a `done` pulse.
- `ram_enable`=0 whenever no issue occurs. `ram_address` is don't-care when `ram_enable`=0, but holds the counter value.
- A FIFO push and pop in the same cycle leave occupancy unchanged. Credit control guarantees no push ever occurs while the FIFO is full.
- `start` is ignored while `busy`=1.
- `reset` asserted mid-transfer aborts immediately. Every register returns to its reset value, and any in-flight RAM data is discarded.

Reset values: state IDLE, `busy`=0, `done`=0, `ram_enable`=0, `ram_address`=0, `out_valid`=0, `out_data`=0, occupancy=0, inflight=0.

## Timing
- Let `start` be sampled at edge E0:
  - cycle 1: `busy`=1, `ram_enable`=1, `ram_address`=`base_addr`
  - cycle 2: `ram_q` holds mem[`base_addr`]
  - cycle 3: `out_valid`=1 with that data
- Startup latency from `start` to first `out_valid` is 3 cycles.
- Throughput is one word per cycle while `out_ready`=1.
- `out_valid` and `out_data` are registered from the FIFO storage and do not depend combinationally on `out_ready`.
- `done` is high in the cycle after the edge that performs the last transfer, and `busy` is 0 in that same cycle.
- `start` is accepted in the cycle where `done`=1, because the block is already IDLE.
- With `out_ready` held low, at most `fifo_depth` RAM reads are issued. Issue resumes the cycle after the first pop frees a credit.

## Test plan
- RAM preloaded with mem[i]=i; `base_addr`=0x010, `length`=8, `out_ready`=1 → `out_data` 0x10…0x17 on 8 consecutive cycles starting cycle 3; `done` one cycle later; 8 `ram_enable` pulses total.
- `base_addr`=0x3FE, `length`=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001; data in that order.
- `length`=16, `out_ready` low for 10 cycles then high → exactly 4 reads issued while stalled, no data lost or duplicated, and all 16 words arrive in order.
- `out_ready` toggling pseudo-randomly, `length`=1024 (full RAM) → 1024 in-order words, a single `done`, and occupancy never exceeds 4.
- `length`=0 → `done` at cycle 1, `busy` never high, no `ram_enable`. A second `start` while `busy`=1 is ignored.
- `reset` pulsed during FETCH → all outputs at reset values the same cycle. A new `start` afterwards reads from its own `base_addr`, with no stale words delivered.
